// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath blocks: default sizes, index
// width helper, flattened-bus index helper and the serializer FSM states.
package matrix_pkg;

  localparam int MAX_SIZE_DFLT   = 10;
  localparam int DATA_WIDTH_DFLT = 32;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  localparam int IDX_W = clog2_min1(MAX_SIZE_DFLT);

  // Bit offset of element (i,j) on a row-major flattened matrix bus.
  function automatic int flat_idx(input int i, input int j, input int max_size, input int dw);
    return (i * max_size + j) * dw;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/matrix_rc_counter.sv
// Row-major row/column walker over a size x size region; clears itself after
// the final element so it is ready for the next matrix.
module matrix_rc_counter
  import matrix_pkg::*;
#(
  parameter int MAX_SIZE = MAX_SIZE_DFLT,
  localparam int IDX_W_L = clog2_min1(MAX_SIZE),
  localparam int SIZE_W  = $clog2(MAX_SIZE + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_adv,
  input  logic [SIZE_W-1:0]  i_size,
  output logic [IDX_W_L-1:0] o_row,
  output logic [IDX_W_L-1:0] o_col,
  output logic               o_last
);

  logic [IDX_W_L-1:0] r_row;
  logic [IDX_W_L-1:0] r_col;
  logic [SIZE_W-1:0]  w_end;
  logic               w_row_end;
  logic               w_col_end;

  assign w_end     = i_size - SIZE_W'(1);
  assign w_row_end = (SIZE_W'(r_row) == w_end);
  assign w_col_end = (SIZE_W'(r_col) == w_end);
  assign o_last    = w_row_end & w_col_end;
  assign o_row     = r_row;
  assign o_col     = r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr || (i_adv && o_last)) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + IDX_W_L'(1);
      end else begin
        r_col <= r_col + IDX_W_L'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_result_serializer.sv
// Snapshots the multiplier's flattened C bus on start and streams the active
// size x size region row-major over a valid/ready interface with a last flag.
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int MAX_SIZE   = MAX_SIZE_DFLT,
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  localparam int IDX_W_L   = clog2_min1(MAX_SIZE),
  localparam int SIZE_W    = $clog2(MAX_SIZE + 1),
  localparam int FLAT_W    = MAX_SIZE * MAX_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           matrix_size,
  input  logic [FLAT_W-1:0]     c_flat,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W_L-1:0]    out_row,
  output logic [IDX_W_L-1:0]    out_col,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [SIZE_W-1:0]     r_size;
  logic [SIZE_W-1:0]     w_eff_size;
  logic                  w_capture;
  logic                  w_cnt_clr;
  logic                  w_cnt_adv;
  logic [IDX_W_L-1:0]    w_row;
  logic [IDX_W_L-1:0]    w_col;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_c_elems [MAX_SIZE][MAX_SIZE];
  logic [DATA_WIDTH-1:0] r_buf     [MAX_SIZE][MAX_SIZE];

  assign w_eff_size = ($unsigned(matrix_size) > $unsigned(32'(MAX_SIZE))) ?
                      SIZE_W'(MAX_SIZE) : matrix_size[SIZE_W-1:0];

  for (genvar gi = 0; gi < MAX_SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_SIZE; gj++) begin : g_col
      assign w_c_elems[gi][gj] = c_flat[flat_idx(gi, gj, MAX_SIZE, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_adv   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_eff_size != '0) begin
            w_capture   = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_STREAM;
          end else begin
            w_state_nxt = ST_FINISH;
          end
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          w_cnt_adv = 1'b1;
          if (w_last) w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_size  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_size <= w_eff_size;
    end
  end

  // Snapshot storage carries no reset; it is only read while streaming.
  always_ff @(posedge clk) begin
    if (w_capture) r_buf <= w_c_elems;
  end

  matrix_rc_counter #(
    .MAX_SIZE (MAX_SIZE)
  ) u_rc_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cnt_clr),
    .i_adv  (w_cnt_adv),
    .i_size (r_size),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_last (w_last)
  );

  assign out_valid = (r_state == ST_STREAM);
  assign out_data  = out_valid ? r_buf[w_row][w_col] : '0;
  assign out_row   = out_valid ? w_row : '0;
  assign out_col   = out_valid ? w_col : '0;
  assign out_last  = out_valid & w_last;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FINISH);

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: a vector table of matrix
// sizes / data patterns / ready patterns plus restart and reset sequences.
module tb_matrix_result_serializer;

  localparam int MS = 10;
  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [31:0]         matrix_size;
  logic [MS*MS*DW-1:0] c_flat;
  logic [DW-1:0]       out_data;
  logic [3:0]          out_row;
  logic [3:0]          out_col;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic                done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] size;
    int          eff;
    int          mul;
    int          add;
    int          mode;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  matrix_result_serializer #(.MAX_SIZE(MS), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_size (matrix_size),
    .c_flat      (c_flat),
    .out_data    (out_data),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Active region gets mul*i+j+add; everything else gets a recognisable marker.
  task automatic fill(input int eff, input int mul, input int add);
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++)
        c_flat[(i*MS+j)*DW +: DW] = (i < eff && j < eff) ? 32'(mul*i + j + add)
                                                          : (32'hDEAD0000 | 32'(i*MS+j));
  endtask

  function automatic logic rdy(input int mode, input int ph);
    case (mode)
      1:       return (ph % 3) == 0;
      2:       return (ph % 2) == 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input bit restart);
    int n   = v.eff * v.eff;
    int k   = 0;
    int cyc = 0;
    int ph  = 0;
    bit rs_done = 1'b0;
    fill(v.eff, v.mul, v.add);
    matrix_size = v.size;
    out_ready   = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < n && cyc < 2000) begin
      int i = k / v.eff;
      int j = k % v.eff;
      out_ready = rdy(v.mode, ph);
      ph++;
      chk("beat_valid", 32'(out_valid), 32'd1);
      chk("beat_data",  out_data, 32'(v.mul*i + j + v.add));
      chk("beat_row",   32'(out_row), 32'(i));
      chk("beat_col",   32'(out_col), 32'(j));
      chk("beat_last",  32'(out_last), 32'(k == n-1));
      chk("beat_busy",  32'(busy), 32'd1);
      if (restart && !rs_done && k == 1) begin
        rs_done = 1'b1;
        for (int e = 0; e < MS*MS; e++) c_flat[e*DW +: DW] = 32'hBAD0_0000 | 32'(e);
        matrix_size = 32'd5;
        start = 1'b1;
      end
      if (out_ready) k++;
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    if (cyc >= 2000) chk("stream_timeout", 32'(k), 32'(n));
    chk("fin_valid", 32'(out_valid), 32'd0);
    chk("fin_done",  32'(done), 32'd1);
    chk("fin_busy",  32'(busy), 32'd1);
    if (restart) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_done",  32'(done), 32'd0);
    chk("idle_busy",  32'(busy), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("idle2_valid", 32'(out_valid), 32'd0);
    chk("idle2_done",  32'(done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'd2,          2, 2,    1,   0};
    vecs[1] = '{32'd3,          3, 10,   0,   1};
    vecs[2] = '{32'd0,          0, 1,    0,   0};
    vecs[3] = '{32'd15,        10, 16,   0,   0};
    vecs[4] = '{32'd1,          1, 5,    7,   2};
    vecs[5] = '{32'hFFFF_FFFF, 10, 3,    100, 2};
    vecs[6] = '{32'd10,        10, 1000, 5,   1};

    rst_n = 1'b0; start = 1'b0; matrix_size = '0; out_ready = 1'b0; c_flat = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_data",  out_data,       32'd0);
    chk("rst_row",   32'(out_row),   32'd0);
    chk("rst_col",   32'(out_col),   32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 7; t++) run_vec(vecs[t], 1'b0);

    // Second start and new c_flat mid-stream, plus start during done: all ignored.
    run_vec(vecs[0], 1'b1);

    // Reset after two beats of a 3x3 stream aborts immediately.
    fill(3, 10, 0);
    matrix_size = 32'd3;
    out_ready   = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_data0", out_data, 32'd0);
    @(negedge clk);
    chk("pre_rst_data1", out_data, 32'd1);
    @(negedge clk);
    chk("pre_rst_data2", out_data, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy",  32'(busy),      32'd0);
    chk("abort_done",  32'(done),      32'd0);
    chk("abort_data",  out_data,       32'd0);
    chk("abort_col",   32'(out_col),   32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("abort_hold_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done",  32'(done),      32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    run_vec(vecs[1], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
- Reader end of the flattened result bus C produced by the parallel matrix multiplier.
- On a start pulse, snapshots the flattened C bus and the active matrix size.
- Streams the active size×size region out in row-major order, one element per accepted beat, on a valid/ready interface with a last flag.
- Sits between the multiplier output and the host/UART/DMA-facing result path.

Parameters:
MAX_SIZE, 10, maximum matrix dimension; same value as the multiplier
DATA_WIDTH, 32, width of one matrix element

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to capture C and begin streaming
matrix_size  input  32  active dimension, sampled on accepted start
c_flat  input  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened C; element (i,j) at bits [((i*MAX_SIZE+j)*DATA_WIDTH) +: DATA_WIDTH]
out_data  output  DATA_WIDTH  current element
out_row  output  clog2(MAX_SIZE) (min 1)  row index of out_data
out_col  output  clog2(MAX_SIZE) (min 1)  column index of out_data
out_valid  output  1  out_data/out_row/out_col/out_last valid
out_ready  input  1  downstream accepts the beat when high together with out_valid
out_last  output  1  final element of the matrix
busy  output  1  capture/stream in progress
done  output  1  one-cycle pulse when the stream completes

Behaviour:
- Interface: one clock, clk; reset asynchronous and active-low, rst_n.
- Reset values: out_valid=0, out_last=0, busy=0, done=0, out_data=0, out_row=0, out_col=0, counters=0, state=IDLE.
- FSM states: IDLE, STREAM, FINISH.
- IDLE:
  - start=1 with eff_size>0 -> capture c_flat into internal buffer, latch eff_size, row=col=0, busy=1, go to STREAM.
  - start=1 with eff_size=0 -> go to FINISH; busy=1 for that cycle; no beats emitted.
- eff_size:
  - matrix_size clamped to MAX_SIZE when matrix_size > MAX_SIZE.
  - 0 when matrix_size = 0.
- Latency: start at cycle t -> out_valid=1 with element (0,0) at cycle t+1.
- STREAM:
  - out_valid=1; out_data = buffer element (row,col).
  - Handshake: beat transfers on out_valid & out_ready.
  - While out_ready=0, out_data/out_row/out_col/out_last are held stable and out_valid stays 1; valid is never withdrawn.
  - On transfer: col+1; when col = eff_size-1, col wraps to 0 and row+1.
  - out_last=1 exactly when row = eff_size-1 and col = eff_size-1.
  - Transfer with out_last=1 -> out_valid=0 next cycle, go to FINISH.
  - Throughput: one beat per cycle while out_ready is held high.
- FINISH: done=1 for exactly one cycle, busy=0 at the next edge, return to IDLE.
- Start handling:
  - start while busy (STREAM/FINISH) is ignored; no restart, no recapture.
  - start in the same cycle done is high is also ignored.
- Snapshot semantics: c_flat and matrix_size changes after capture do not affect the stream.
- Beat count: exactly eff_size² beats per accepted start.
- Elements outside the active region are never emitted.
- Reset mid-stream: immediate abort. All outputs return to reset values, no done pulse, buffer contents don't care.
- out_ready is ignored when out_valid=0.

Decomposition:
- Shared package matrix_pkg:
  - MAX_SIZE and DATA_WIDTH defaults
  - IDX_W = clog2(MAX_SIZE) (min 1)
  - flat-index helper function, (i*MAX_SIZE+j)*DATA_WIDTH
  - FSM state enum typedef
- One natural sub-module: matrix_rc_counter.
  - Row/column counter with eff_size wrap, advance enable, and last-flag generation.
  - Reusable by the planned input-side matrix loader.

Test Plan:
- matrix_size=2, C(0,0)=1, C(0,1)=2, C(1,0)=3, C(1,1)=4, out_ready=1 -> beats 1,2,3,4 on consecutive cycles; (row,col)=(0,0),(0,1),(1,0),(1,1); out_last only on 4; done 1 cycle after beat 4; busy low after done.
- matrix_size=3, C(i,j)=10*i+j, out_ready toggled 1,0,0,1,... -> 9 beats 0,1,2,10,11,12,20,21,22 in order. Data held stable during stalls; no beat dropped or duplicated.
- matrix_size=0 -> no out_valid; done pulses within 2 cycles of start. matrix_size=15 with MAX_SIZE=10 -> exactly 100 beats, last at (9,9).
- Start size 2, then change c_flat and pulse start again mid-stream -> original 4 values emitted, second start ignored, single done.
- Assert rst_n=0 after beat 2 of a 3×3 stream -> out_valid/busy/done=0 immediately, no done pulse. A new start after release streams from (0,0).
